mips_grf_2w_dump: RTL and testbench
===================================

// Module: mips_grf_2w_dump
// PURPOSE
//  - Parametrised general register file for the MIPS pipeline.
//  - Two write ports (W0 = main WB, W1 = secondary/late WB) and NRD combinational read ports; register 0 hardwired to zero.
//  - Includes a ready/valid dump engine that streams every register out for end-of-test comparison against the golden model.
// PARAMETERS
//  - DATA_W  32  register width in bits
//  - NREG    32  number of registers; power of 2, >=4; AW = $clog2(NREG)
//  - NRD     2   number of read ports, 1..4
// PORTS
//  - clk         in   1         clock; all state updates on posedge
//  - reset       in   1         synchronous, active-high
//  - we0         in   1         write enable, port 0
//  - wa0         in   AW        write address, port 0
//  - wd0         in   DATA_W    write data, port 0
//  - we1         in   1         write enable, port 1 (higher priority)
//  - wa1         in   AW        write address, port 1
//  - wd1         in   DATA_W    write data, port 1
//  - ra          in   NRD*AW    read addresses; port k = ra[k*AW +: AW]
//  - rd          out  NRD*DATA_W read data; port k = rd[k*DATA_W +: DATA_W]
//  - dump_req    in   1         1-cycle pulse: start a dump
//  - dump_busy   out  1         high from the cycle after an accepted req until done
//  - dump_valid  out  1         dump_idx/dump_data valid
//  - dump_ready  in   1         consumer accepts the current beat
//  - dump_idx    out  AW        register index of the current beat
//  - dump_data   out  DATA_W    register contents at that index
//  - dump_done   out  1         1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  - Reset (sync): all registers := 0; FSM := IDLE; dump_valid = dump_done = dump_busy = 0; dump_idx = 0.
//  - While reset is high, writes are ignored and no bypass is applied.
//  - Write: at posedge, if weN && waN != 0 then reg[waN] := wdN. A write to address 0 is dropped.
//  - Same-address collision (we0 && we1 && wa0 == wa1): port 1 wins; port 0 data is lost.
//  - Read: rd[k] = reg[ra[k]], combinational, zero latency. ra[k] == 0 always returns 0.
//  - Dump FSM states: IDLE, RUN, DONE.
//    - IDLE: on dump_req -> RUN with dump_idx := 0.
//    - RUN: dump_valid = 1; dump_data = reg[dump_idx], the value committed as of the current cycle.
//      - On dump_valid && dump_ready: if dump_idx == NREG-1 -> DONE, else dump_idx := dump_idx + 1.
//      - While dump_ready = 0, dump_idx holds. dump_data may change if a write commits meanwhile; this is intended.
//    - DONE: dump_done = 1 for exactly one cycle; then -> IDLE with dump_idx := 0.
//  - dump_req is ignored in RUN and DONE; no queuing.
//  - dump_busy = (state != IDLE).
//  - Writes and reads run normally during a dump; the dump never stalls the pipeline.
//  - Reset asserted mid-dump: the FSM aborts to IDLE the next edge; no dump_done pulse.
//  - Index arithmetic is AW bits wide; the last beat is detected explicitly, never by wrap-around.
// CONFIGURATION
//  - Macro GRF_BYPASS_EN.
//  - Defined: internal write-to-read forwarding.
//    - rd[k] = wd1 if (we1 && wa1 != 0 && wa1 == ra[k]);
//    - else wd0 if (we0 && wa0 != 0 && wa0 == ra[k]);
//    - else reg[ra[k]].
//    - Forwarding is suppressed while reset is high.
//    - The dump path is never forwarded; it always shows committed state.
//  - Not defined: rd shows committed state only; a write becomes visible on reads the cycle after the edge.
// TESTING
//  - Reset, then read all addresses -> all 0; dump_valid = dump_done = dump_busy = 0.
//  - we0 = 1, wa0 = 5, wd0 = 32'hDEAD_BEEF; next cycle ra[0] = 5 -> rd[0] = DEAD_BEEF. Same write with wa0 = 0, ra[0] = 0 -> rd[0] = 0.
//  - Collision: we0 = we1 = 1, wa0 = wa1 = 7, wd0 = 1, wd1 = 2 -> reg7 = 2.
//    - With GRF_BYPASS_EN, same cycle ra[1] = 7 -> rd[1] = 2.
//    - Without it, rd[1] shows the old value (0) in that cycle.
//  - Write reg i = i*16 for i = 1..31; pulse dump_req with dump_ready = 1:
//    - 32 beats, idx 0..31, data 0, 0x10 .. 0x1F0;
//    - dump_done high exactly one cycle after beat 31.
//  - Dump with dump_ready toggled 1/0 each cycle, plus a second dump_req mid-run:
//    - idx holds while ready = 0;
//    - the extra req is ignored; exactly 32 beats.
//  - Assert reset while dump_idx = 10 -> next cycle dump_busy = 0, dump_valid = 0, no dump_done, reg5 reads 0.

Source files
------------

// File: rtl/mips_grf_2w_dump.sv
// mips_grf_2w_dump: general register file for the MIPS pipeline.
// Two write ports (port 1 wins on same-address collisions) and NRD
// combinational read ports. Register 0 always reads as zero.
// A ready/valid dump engine streams every register out in index order
// so that end-of-test state can be compared with a golden model.
// Optional feature: define GRF_BYPASS_EN to forward same-cycle write
// data to the read ports. The dump path always shows committed state.
module mips_grf_2w_dump #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we0,
  input  logic [AW-1:0]         wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rd,
  input  logic                  dump_req,
  output logic                  dump_busy,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [AW-1:0]         dump_idx,
  output logic [DATA_W-1:0]     dump_data,
  output logic                  dump_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  dump_state_t state;

  logic [DATA_W-1:0] regs [NREG];

  // Register array update: synchronous clear, then both write ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is cleared in a loop because every register must
      // read zero after reset; this keeps it as flops rather than a RAM,
      // which the combinational read ports need anyway.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments; port 1 is written after port 0 so
      // on a same-address collision the later assignment (port 1) wins.
      if (we0 && wa0 != '0) regs[wa0] <= wd0;
      if (we1 && wa1 != '0) regs[wa1] <= wd1;
    end
  end

  // Combinational read ports, with optional write-to-read forwarding.
  always_comb begin
    // NOTE: rd gets a full default before the loop so no bit is left
    // unassigned on any path, which would otherwise infer a latch.
    rd = '0;
    for (int k = 0; k < NRD; k++) begin
      if (ra[k*AW +: AW] != '0) begin
        rd[k*DATA_W +: DATA_W] = regs[ra[k*AW +: AW]];
`ifdef GRF_BYPASS_EN
        if (!reset) begin
          if (we1 && wa1 == ra[k*AW +: AW])
            rd[k*DATA_W +: DATA_W] = wd1;
          else if (we0 && wa0 == ra[k*AW +: AW])
            rd[k*DATA_W +: DATA_W] = wd0;
        end
`endif
      end
    end
  end

  // Dump data always reflects committed state at the current index.
  always_comb begin
    dump_data = (dump_idx == '0) ? '0 : regs[dump_idx];
  end

  // Dump engine: IDLE -> RUN (one beat per accepted handshake) -> DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      dump_busy  <= 1'b0;
      dump_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_req) begin
            state      <= RUN;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
            dump_idx   <= '0;
          end
        end
        RUN: begin
          if (dump_valid && dump_ready) begin
            if (dump_idx == LAST_IDX) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_idx <= dump_idx + 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_done <= 1'b0;
          dump_busy <= 1'b0;
          dump_idx  <= '0;
        end
        default: begin
          state      <= IDLE;
          dump_valid <= 1'b0;
          dump_done  <= 1'b0;
          dump_busy  <= 1'b0;
          dump_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_grf_2w_dump.sv
// Self-checking bench for mips_grf_2w_dump with default parameters.
// A plain array model holds the architectural register state; expected
// read and dump values are computed from it using the register-file rules.
module tb_mips_grf_2w_dump;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int NRD    = 2;
  localparam int AW     = 5;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  we0, we1;
  logic [AW-1:0]         wa0, wa1;
  logic [DATA_W-1:0]     wd0, wd1;
  logic [NRD*AW-1:0]     ra;
  logic [NRD*DATA_W-1:0] rd;
  logic                  dump_req, dump_busy, dump_valid, dump_ready, dump_done;
  logic [AW-1:0]         dump_idx;
  logic [DATA_W-1:0]     dump_data;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] model [NREG];

  mips_grf_2w_dump #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, applying the architectural write rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREG; i++) model[i] = '0;
    end else begin
      if (we0 && wa0 != 0) model[wa0] = wd0;
      if (we1 && wa1 != 0) model[wa1] = wd1;
    end
    #1;
  endtask

  // Expected read value for an address given the currently driven inputs.
  function automatic logic [DATA_W-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef GRF_BYPASS_EN
    if (!reset) begin
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
    end
`endif
    return model[a];
  endfunction

  task automatic idle_inputs();
    we0 = 0; we1 = 0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    ra = '0; dump_req = 0; dump_ready = 0;
  endtask

  task automatic test_reset();
    logic [DATA_W-1:0] got;
    idle_inputs();
    reset = 1;
    tick(); tick();
    // Writes and forwarding are suppressed while reset is high.
    we0 = 1; wa0 = 5'd3; wd0 = 32'h1234_5678; ra[AW-1:0] = 5'd3; #1;
    checks++;
    if (rd[DATA_W-1:0] !== 32'h0)
      $display("FAIL reset_no_bypass: got %h want 0", rd[DATA_W-1:0]);
    if (rd[DATA_W-1:0] !== 32'h0) errors++;
    tick();
    we0 = 0; reset = 0; #1;
    checks++;
    if (dump_valid !== 0 || dump_done !== 0 || dump_busy !== 0 || dump_idx !== '0) begin
      errors++;
      $display("FAIL reset_dump_outputs: valid=%b done=%b busy=%b idx=%0d want 0/0/0/0",
               dump_valid, dump_done, dump_busy, dump_idx);
    end
    for (int a = 0; a < NREG; a++) begin
      ra[AW-1:0] = AW'(a); ra[2*AW-1:AW] = AW'(NREG - 1 - a); #1;
      got = rd[DATA_W-1:0];
      checks++;
      if (got !== 32'h0 || rd[2*DATA_W-1:DATA_W] !== 32'h0) begin
        errors++;
        $display("FAIL reset_read a=%0d: got %h/%h want 0", a, got, rd[2*DATA_W-1:DATA_W]);
      end
    end
  endtask

  task automatic test_write_basic();
    idle_inputs();
    we0 = 1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    tick();
    we0 = 0; ra[AW-1:0] = 5'd5; #1;
    checks++;
    if (rd[DATA_W-1:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_reg5: got %h want deadbeef", rd[DATA_W-1:0]);
    end
    we0 = 1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF;
    tick();
    we0 = 0; ra[AW-1:0] = 5'd0; #1;
    checks++;
    if (rd[DATA_W-1:0] !== 32'h0) begin
      errors++;
      $display("FAIL write_reg0: got %h want 0", rd[DATA_W-1:0]);
    end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] want;
    idle_inputs();
    we0 = 1; we1 = 1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'd1; wd1 = 32'd2;
    ra[2*AW-1:AW] = 5'd7; #1;
`ifdef GRF_BYPASS_EN
    want = 32'd2;
`else
    want = 32'd0;
`endif
    checks++;
    if (rd[2*DATA_W-1:DATA_W] !== want) begin
      errors++;
      $display("FAIL collision_same_cycle: got %h want %h", rd[2*DATA_W-1:DATA_W], want);
    end
    tick();
    we0 = 0; we1 = 0; #1;
    checks++;
    if (rd[2*DATA_W-1:DATA_W] !== 32'd2) begin
      errors++;
      $display("FAIL collision_committed: got %h want 2", rd[2*DATA_W-1:DATA_W]);
    end
  endtask

  task automatic test_random_rw();
    logic [DATA_W-1:0] want;
    idle_inputs();
    for (int c = 0; c < 300; c++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      wa0 = AW'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      ra[AW-1:0] = ($urandom_range(0, 2) == 0) ? wa0 : AW'($urandom);
      ra[2*AW-1:AW] = ($urandom_range(0, 2) == 0) ? wa1 : AW'($urandom);
      #1;
      for (int k = 0; k < NRD; k++) begin
        want = exp_rd(ra[k*AW +: AW]);
        checks++;
        if (rd[k*DATA_W +: DATA_W] !== want) begin
          errors++;
          $display("FAIL random_read c=%0d port=%0d addr=%0d: got %h want %h",
                   c, k, ra[k*AW +: AW], rd[k*DATA_W +: DATA_W], want);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  // Runs one dump; every cycle the expected valid/done/busy/idx/data are
  // derived from beats accepted so far and the model.
  task automatic run_dump(input string tag, input bit toggle, input bit extra_req,
                          input bit rand_wr);
    int  beats = 0;
    int  last_acc = -10;
    int  dones = 0;
    int  cyc = 0;
    bit  finished = 0;
    bit  exp_valid, exp_done, exp_busy;
    idle_inputs();
    dump_req = 1;
    tick();
    dump_req = 0;
    while (cyc < 300 && !finished) begin
      dump_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      dump_req = extra_req && (cyc == 9);
      if (rand_wr) begin
        we0 = 1'($urandom); wa0 = AW'($urandom); wd0 = $urandom;
        we1 = 1'($urandom); wa1 = AW'($urandom); wd1 = $urandom;
      end
      #1;
      exp_valid = (beats < NREG);
      exp_done  = (beats == NREG) && (last_acc == cyc - 1);
      exp_busy  = exp_valid || exp_done;
      checks++;
      if (dump_valid !== exp_valid || dump_done !== exp_done || dump_busy !== exp_busy) begin
        errors++;
        $display("FAIL %s_ctrl cyc=%0d: valid/done/busy=%b%b%b want %b%b%b",
                 tag, cyc, dump_valid, dump_done, dump_busy, exp_valid, exp_done, exp_busy);
      end
      if (dump_done === 1'b1) dones++;
      if (exp_valid) begin
        checks++;
        if (dump_idx !== AW'(beats) || dump_data !== model[beats]) begin
          errors++;
          $display("FAIL %s_beat cyc=%0d: idx=%0d data=%h want idx=%0d data=%h",
                   tag, cyc, dump_idx, dump_data, beats, model[beats]);
        end
        if (dump_ready) begin
          beats++;
          last_acc = cyc;
        end
      end
      if (!exp_busy) finished = 1;
      else begin
        tick();
        cyc++;
      end
    end
    checks++;
    if (!finished || beats != NREG || dones != 1) begin
      errors++;
      $display("FAIL %s_summary: finished=%0b beats=%0d dones=%0d want 1/%0d/1",
               tag, finished, beats, dones, NREG);
    end
    idle_inputs();
  endtask

  task automatic test_dump_full();
    idle_inputs();
    for (int i = 1; i < NREG; i++) begin
      we0 = 1; wa0 = AW'(i); wd0 = DATA_W'(i * 16);
      tick();
    end
    idle_inputs();
    run_dump("dump_full", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_dump_backpressure();
    run_dump("dump_bp", 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_dump();
    int  n = 0;
    idle_inputs();
    we0 = 1; wa0 = 5'd5; wd0 = 32'h0000_0055;
    tick();
    idle_inputs();
    dump_ready = 1; dump_req = 1;
    tick();
    dump_req = 0;
    while (dump_idx !== 5'd10 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (dump_idx !== 5'd10) begin
      errors++;
      $display("FAIL mid_dump_reach_idx10: idx=%0d want 10", dump_idx);
    end
    reset = 1; ra[AW-1:0] = 5'd5;
    tick();
    checks++;
    if (dump_busy !== 0 || dump_valid !== 0 || dump_done !== 0 || rd[DATA_W-1:0] !== 32'h0) begin
      errors++;
      $display("FAIL mid_dump_reset: busy=%b valid=%b done=%b reg5=%h want 0/0/0/0",
               dump_busy, dump_valid, dump_done, rd[DATA_W-1:0]);
    end
    reset = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (dump_done !== 0 || dump_valid !== 0 || rd[DATA_W-1:0] !== 32'h0) begin
        errors++;
        $display("FAIL post_reset_idle c=%0d: done=%b valid=%b reg5=%h want 0/0/0",
                 c, dump_done, dump_valid, rd[DATA_W-1:0]);
      end
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    for (int i = 0; i < NREG; i++) model[i] = '0;
    test_reset();
    test_write_basic();
    test_collision();
    test_random_rw();
    test_dump_full();
    test_dump_backpressure();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
